multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle control unit for the RV32I core: next-generation replacement for the single-cycle controller, driving a shared-memory, non-pipelined datapath with a Moore state machine. It decodes lw, sw, R-type, I-type ALU, beq, optional bne, and jal over 3–5 cycles per instruction. It optionally stalls on a memory ready handshake, and flags unsupported opcodes. It sits between the instruction register and the multi-cycle datapath muxes, register file, PC and unified memory.

## Interface
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for MemReady; 0 = MemReady ignored, each of those states lasts 1 cycle.
- BNE_EN, 1: 1 = branch opcode with funct3=001 is decoded as bne; 0 = only beq (funct3=000) is legal.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; state forced to FETCH.
- op  input  7  instruction opcode from IR.
- funct3  input  3  instruction funct3.
- funct7b5  input  1  instruction bit 30.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory access completes this cycle.
- MemReq  output  1  memory access request.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address mux: 0 = PC, 1 = ALUOut/Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  IR/OldPC enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  00 = rs2, 01 = Imm, 10 = constant 4.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- Illegal  output  1  unsupported opcode/funct3 seen in DECODE.
- State  output  4  current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11–15 are unreachable and return to FETCH.
- Transitions:
  - FETCH -> DECODE when ready (ready = MemReady if MEM_HANDSHAKE, else 1); otherwise hold.
  - DECODE: op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; anything else -> FETCH.
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD -> MEMWB when ready. MEMWRITE -> FETCH when ready.
  - EXECR/EXECI -> ALUWB; JAL -> ALUWB.
  - MEMWB, ALUWB, BRANCH -> FETCH.
- Outputs per state (unlisted = 0):
  - FETCH: MemReq=1, AdrSrc=0, IRWrite=ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: MemReq=1, AdrSrc=1, ResultSrc=00, MemWrite=1 for the whole state.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Branch condition and PC enable:
  - take = Zero if funct3=000; take = ~Zero if funct3=001 and BNE_EN; otherwise 0.
  - PCWrite = PCUpdate | (Branch & take).
- ImmSrc is combinational from op: lw/I-type/other 00, sw 01, branch 10, jal 11.
- ALUControl:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 decodes funct3: 000 -> 001 if op[5]&funct7b5, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 000.
- Illegal = 1 in DECODE when op is not one of the six listed opcodes, or op=1100011 with unsupported funct3. An illegal branch still goes through BRANCH with take=0; no architectural write occurs.

## Timing
- Reset (synchronous): on the first rising edge with reset=1, State=FETCH. While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 and MemReq=0. All other outputs show the FETCH decode.
- Outputs are combinational from State, plus Zero, MemReady, op and funct3; there are no output registers.
- Latency with ready always 1: lw 5 cycles, sw 4, R/I-type 4, beq/bne 3, jal 4, illegal 2.
- Each wait cycle with MemReady=0 in FETCH/MEMREAD/MEMWRITE adds exactly 1 cycle. IRWrite/PCWrite pulse exactly once per FETCH, in its final cycle.
- reset asserted mid-instruction: next state is FETCH regardless of the current state; no write strobes are asserted in that cycle.

## Test plan
- Reset then lw (op=0000011), MemReady=1 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4, ResultSrc=01.
- sw with MemReady low for 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, State stays 5, then goes to 0.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; add (funct7b5=0) -> 000; funct3=111 -> 010.
- beq with Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> 0. bne with BNE_EN=1, Zero=0 -> PCWrite=1; with BNE_EN=0 -> Illegal=1, PCWrite=0.
- op=1111111 -> Illegal=1 in DECODE, next State=0, no RegWrite/MemWrite.
- reset=1 while State=4 (MEMWB) -> RegWrite=0 in that cycle, State=0 next cycle; MEM_HANDSHAKE=0 with MemReady=0 -> lw still completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style control unit for a non-pipelined RV32I datapath that uses one
// shared memory for instructions and data. It supports lw, sw, R-type,
// I-type ALU, beq, an optional bne, and jal. Each instruction takes 3-5 cycles.
// Memory states can optionally stall on MemReady. Unsupported encodings
// are flagged in DECODE.
//
// Parameters
//   MEM_HANDSHAKE  1: FETCH/MEMREAD/MEMWRITE wait for MemReady
//                  0: MemReady ignored, those states last one cycle
//   BNE_EN         1: branch funct3=001 decodes as bne; 0: only beq legal
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op, funct3,
//   funct7b5          instruction fields from the IR
//   Zero              ALU zero flag
//   MemReady          memory access completes this cycle
//   MemReq, MemWrite  memory request / write strobe
//   PCWrite, IRWrite,
//   RegWrite          architectural write enables
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl  datapath mux and ALU controls
//   Illegal           unsupported opcode/funct3 seen in DECODE
//   State             current state encoding (debug)
//
// Handshake: a memory access in FETCH/MEMREAD/MEMWRITE completes in a
// cycle when ready is high. ready equals MemReady when MEM_HANDSHAKE is set,
// and is always 1 otherwise. The FSM holds its state while ready is low.
// MemReq stays high for the whole state.
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BNE_EN        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state_q;
    state_t     dec_state;
    logic       ready;
    logic       take;
    logic       br_legal;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       memreq_d;
    logic       memwrite_d;
    logic       irwrite_d;
    logic       regwrite_d;

    assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;
    assign State = state_q;

    // Branch funct3 values this build can execute.
    assign br_legal = (funct3 == 3'b000) || ((funct3 == 3'b001) && BNE_EN);

    always_comb begin
        take = 1'b0;
        if (funct3 == 3'b000)
            take = Zero;
        else if ((funct3 == 3'b001) && BNE_EN)
            take = ~Zero;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    if (ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECR;
                        OP_ITYPE:     state_q <= S_EXECI;
                        OP_BR:        state_q <= S_BRANCH;
                        OP_JAL:       state_q <= S_JAL;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (ready) state_q <= S_MEMWB;
                S_MEMWRITE: if (ready) state_q <= S_FETCH;
                S_EXECR:    state_q <= S_ALUWB;
                S_EXECI:    state_q <= S_ALUWB;
                S_JAL:      state_q <= S_ALUWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_ALUWB:    state_q <= S_FETCH;
                S_BRANCH:   state_q <= S_FETCH;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-state outputs. While reset is high the FETCH decode is shown,
    // so the datapath muxes settle to their fetch settings. All strobes
    // are then gated off below.
    // ------------------------------------------------------------------
    always_comb begin
        dec_state  = reset ? S_FETCH : state_q;
        memreq_d   = 1'b0;
        memwrite_d = 1'b0;
        irwrite_d  = 1'b0;
        regwrite_d = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        Illegal    = 1'b0;
        case (dec_state)
            S_FETCH: begin
                memreq_d  = 1'b1;
                irwrite_d = ready;
                pc_update = ready;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL: Illegal = 1'b0;
                    OP_BR:   Illegal = ~br_legal;
                    default: Illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                memreq_d = 1'b1;
                AdrSrc   = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                regwrite_d = 1'b1;
            end
            S_MEMWRITE: begin
                memreq_d   = 1'b1;
                AdrSrc     = 1'b1;
                memwrite_d = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                regwrite_d = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Illegal branches reach BRANCH with take=0, so no PC write occurs.
    assign MemReq   = memreq_d   & ~reset;
    assign MemWrite = memwrite_d & ~reset;
    assign IRWrite  = irwrite_d  & ~reset;
    assign RegWrite = regwrite_d & ~reset;
    assign PCWrite  = (pc_update | (branch & take)) & ~reset;

    // ------------------------------------------------------------------
    // Immediate format, from opcode alone
    // ------------------------------------------------------------------
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder. sub is selected only for R-type (op[5]=1) with
    // funct7b5 set. For I-type, bit 30 belongs to the immediate.
    // ------------------------------------------------------------------
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule
